// File: rtl/pcie_tlp_pkg.sv
// Shared TLP encodings for the endpoint application layer: header field constants,
// the c2h transmit state enum and a 3-DW Memory Write header builder.
package pcie_tlp_pkg;

  localparam logic [2:0] FMT_3DW_DATA = 3'b010;
  localparam logic [4:0] TYPE_MEM     = 5'b00000;
  localparam logic [9:0] MWR_LEN_DW   = 10'd8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_H01,
    TX_H2D0,
    TX_D12,
    TX_D34,
    TX_D56,
    TX_D7
  } tx_state_e;

  // Returns {DW2, DW1, DW0}; the low two address bits are forced to zero (DW aligned).
  function automatic logic [95:0] mwr32_hdr(input logic [15:0] req_id,
                                            input logic [31:0] addr);
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    dw0 = {FMT_3DW_DATA, TYPE_MEM, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0,
           2'b00, 2'b00, MWR_LEN_DW};
    dw1 = {req_id, 8'h00, 4'hF, 4'hF};
    dw2 = addr & 32'hFFFF_FFFC;
    return {dw2, dw1, dw0};
  endfunction

endpackage

// File: rtl/pcie_tlp_hdr_gen.sv
// Combinational 32-bit-address Memory Write header generator, shared with the
// completion path so both build headers identically.
module pcie_tlp_hdr_gen
  import pcie_tlp_pkg::*;
(
  input  logic [15:0] req_id,
  input  logic [31:0] addr,
  output logic [95:0] hdr
);

  assign hdr = mwr32_hdr(req_id, addr);

endmodule

// File: rtl/pcie_c2h_mwr_tx.sv
// SoftMC-to-host transmit engine: each accepted 256-bit stream beat becomes one
// 8-DW Memory Write TLP on the 64-bit s_axis_tx interface, aimed at a host ring.
module pcie_c2h_mwr_tx
  import pcie_tlp_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int STREAM_WIDTH = 256,
  parameter int RING_AW      = 16
)(
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic                    user_lnk_up,
  input  logic [15:0]             cfg_completer_id,
  input  logic [15:0]             cfg_command,
  input  logic                    c2h_enable,
  input  logic [31:0]             c2h_base_addr,
  input  logic [STREAM_WIDTH-1:0] softmc_c2h_tdata,
  input  logic                    softmc_c2h_tvalid,
  output logic                    softmc_c2h_tready,
  input  logic                    softmc_c2h_tlast,
  input  logic                    s_axis_tx_tready,
  output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
  output logic                    s_axis_tx_tlast,
  output logic                    s_axis_tx_tvalid,
  output logic                    tx_src_dsc,
  output logic [RING_AW-1:0]      c2h_wr_offset,
  output logic                    c2h_done
);

  localparam logic [RING_AW-1:0] TLP_BYTES = RING_AW'(32);

  tx_state_e               state_q, state_d;
  logic [STREAM_WIDTH-1:0] beat_q, beat_d;
  logic                    last_q, last_d;
  logic [RING_AW-1:0]      addr_q, addr_d;
  logic [RING_AW-1:0]      offset_q, offset_d;
  logic [C_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
  logic                    tlast_q, tlast_d;
  logic                    tvalid_q, tvalid_d;
  logic                    done_q, done_d;

  logic                    run;
  logic                    kill;
  logic                    accept;
  logic                    tx_adv;
  logic [95:0]             hdr;
  logic                    unused_bits;

  function automatic logic [31:0] pdw(input logic [STREAM_WIDTH-1:0] b, input int i);
    return b[32*i +: 32];
  endfunction

  assign run    = user_lnk_up & cfg_command[2] & c2h_enable;
  // The core drops in-flight TLPs on link loss, so that is treated exactly like reset.
  assign kill   = user_reset | ~user_lnk_up;
  assign accept = softmc_c2h_tready & softmc_c2h_tvalid;
  assign tx_adv = tvalid_q & s_axis_tx_tready;

  assign softmc_c2h_tready = run & ~user_reset & (state_q == TX_IDLE);

  assign unused_bits = ^{cfg_command[15:3], cfg_command[1:0], c2h_base_addr[RING_AW-1:0]};

  pcie_tlp_hdr_gen u_hdr (
    .req_id (cfg_completer_id),
    .addr   ({c2h_base_addr[31:RING_AW], addr_q}),
    .hdr    (hdr)
  );

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    last_d   = last_q;
    addr_d   = addr_q;
    offset_d = offset_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    done_d   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (accept) begin
          beat_d   = softmc_c2h_tdata;
          last_d   = softmc_c2h_tlast;
          addr_d   = offset_q;
          state_d  = TX_H01;
          tdata_d  = hdr[63:0];
          tkeep_d  = '1;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
        end else if (!c2h_enable) begin
          offset_d = '0;
        end
      end
      TX_H01: begin
        if (tx_adv) begin
          state_d = TX_H2D0;
          tdata_d = {pdw(beat_q, 0), hdr[95:64]};
        end
      end
      TX_H2D0: begin
        if (tx_adv) begin
          state_d = TX_D12;
          tdata_d = {pdw(beat_q, 2), pdw(beat_q, 1)};
        end
      end
      TX_D12: begin
        if (tx_adv) begin
          state_d = TX_D34;
          tdata_d = {pdw(beat_q, 4), pdw(beat_q, 3)};
        end
      end
      TX_D34: begin
        if (tx_adv) begin
          state_d = TX_D56;
          tdata_d = {pdw(beat_q, 6), pdw(beat_q, 5)};
        end
      end
      TX_D56: begin
        if (tx_adv) begin
          state_d = TX_D7;
          tdata_d = {32'h0, pdw(beat_q, 7)};
          tkeep_d = KEEP_WIDTH'(8'h0F);
          tlast_d = 1'b1;
        end
      end
      TX_D7: begin
        // Ring offset wraps inside RING_AW bits; the base is never carried into.
        if (tx_adv) begin
          state_d  = TX_IDLE;
          tdata_d  = '0;
          tkeep_d  = '0;
          tlast_d  = 1'b0;
          tvalid_d = 1'b0;
          offset_d = offset_q + TLP_BYTES;
          done_d   = last_q;
        end
      end
      default: begin
        state_d  = TX_IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (kill) begin
      state_q  <= TX_IDLE;
      offset_q <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge user_clk) begin
    beat_q <= beat_d;
    last_q <= last_d;
    addr_q <= addr_d;
  end

  assign s_axis_tx_tdata  = tdata_q;
  assign s_axis_tx_tkeep  = tkeep_q;
  assign s_axis_tx_tlast  = tlast_q;
  assign s_axis_tx_tvalid = tvalid_q;
  assign tx_src_dsc       = 1'b0;
  assign c2h_wr_offset    = offset_q;
  assign c2h_done         = done_q;

endmodule

// File: tb/tb_pcie_c2h_mwr_tx.sv
// Bench for pcie_c2h_mwr_tx: directed vector table, randomized traffic with TX
// backpressure against a DW-list reference model, and reset / link-loss sequences.
module tb_pcie_c2h_mwr_tx;

  localparam int RING_AW   = 8;
  localparam int RING_SIZE = 1 << RING_AW;

  logic                user_clk = 1'b0;
  logic                user_reset;
  logic                user_lnk_up;
  logic [15:0]         cfg_completer_id;
  logic [15:0]         cfg_command;
  logic                c2h_enable;
  logic [31:0]         c2h_base_addr;
  logic [255:0]        softmc_c2h_tdata;
  logic                softmc_c2h_tvalid;
  logic                softmc_c2h_tready;
  logic                softmc_c2h_tlast;
  logic                s_axis_tx_tready;
  logic [63:0]         s_axis_tx_tdata;
  logic [7:0]          s_axis_tx_tkeep;
  logic                s_axis_tx_tlast;
  logic                s_axis_tx_tvalid;
  logic                tx_src_dsc;
  logic [RING_AW-1:0]  c2h_wr_offset;
  logic                c2h_done;

  always #5 user_clk = ~user_clk;

  pcie_c2h_mwr_tx #(.RING_AW(RING_AW)) dut (
    .user_clk          (user_clk),
    .user_reset        (user_reset),
    .user_lnk_up       (user_lnk_up),
    .cfg_completer_id  (cfg_completer_id),
    .cfg_command       (cfg_command),
    .c2h_enable        (c2h_enable),
    .c2h_base_addr     (c2h_base_addr),
    .softmc_c2h_tdata  (softmc_c2h_tdata),
    .softmc_c2h_tvalid (softmc_c2h_tvalid),
    .softmc_c2h_tready (softmc_c2h_tready),
    .softmc_c2h_tlast  (softmc_c2h_tlast),
    .s_axis_tx_tready  (s_axis_tx_tready),
    .s_axis_tx_tdata   (s_axis_tx_tdata),
    .s_axis_tx_tkeep   (s_axis_tx_tkeep),
    .s_axis_tx_tlast   (s_axis_tx_tlast),
    .s_axis_tx_tvalid  (s_axis_tx_tvalid),
    .tx_src_dsc        (tx_src_dsc),
    .c2h_wr_offset     (c2h_wr_offset),
    .c2h_done          (c2h_done)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } txw_t;

  typedef struct {
    logic [15:0] id;
    logic [31:0] base;
    logic [31:0] seed;
    logic        last;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] w5;
    logic [7:0]  off;
    int          done_inc;
  } vec_t;

  txw_t        exp_q[$];
  vec_t        vec[3];
  int          n_pass = 0;
  int          n_total = 0;
  int          ref_off = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  int          widx = 0;
  logic [63:0] cap[8];
  logic [31:0] last_dw2 = '0;
  bit          bp_en = 0;
  bit          hs_pending = 0;
  int          stall = 0;
  bit          stall_prev = 0;
  logic [63:0] sd_data = '0;
  logic [7:0]  sd_keep = '0;
  logic        sd_last = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference: a TLP is the list {DW0, DW1, DW2, D0..D7, pad} sent two DWs per beat.
  task automatic push_tlp(input logic [15:0] id, input logic [31:0] base,
                          input int off, input logic [255:0] data);
    logic [31:0] dws[12];
    txw_t        w;
    dws[0]  = 32'h4000_0008;
    dws[1]  = {id, 16'h00FF};
    dws[2]  = (base & ~32'(RING_SIZE - 1)) + 32'(off);
    for (int i = 0; i < 8; i++) dws[3 + i] = data[32*i +: 32];
    dws[11] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      w.d = {dws[2*k + 1], dws[2*k]};
      w.k = (k == 5) ? 8'h0F : 8'hFF;
      w.l = (k == 5);
      exp_q.push_back(w);
    end
  endtask

  always @(negedge user_clk) begin
    txw_t e;
    if (stall_prev) begin
      check("stall_tvalid", 64'(s_axis_tx_tvalid), 64'd1);
      check("stall_tdata", s_axis_tx_tdata, sd_data);
      check("stall_tkeep", 64'(s_axis_tx_tkeep), 64'(sd_keep));
      check("stall_tlast", 64'(s_axis_tx_tlast), 64'(sd_last));
    end
    stall_prev = s_axis_tx_tvalid && !s_axis_tx_tready;
    sd_data = s_axis_tx_tdata;
    sd_keep = s_axis_tx_tkeep;
    sd_last = s_axis_tx_tlast;
    if (s_axis_tx_tvalid && s_axis_tx_tready) begin
      check("tx_beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_tdata", s_axis_tx_tdata, e.d);
        check("tx_tkeep", 64'(s_axis_tx_tkeep), 64'(e.k));
        check("tx_tlast", 64'(s_axis_tx_tlast), 64'(e.l));
      end
      cap[widx % 8] = s_axis_tx_tdata;
      if (widx == 1) last_dw2 = s_axis_tx_tdata[31:0];
      widx = s_axis_tx_tlast ? 0 : widx + 1;
      hs_pending = 1;
    end
    if (c2h_done) done_cnt++;
  end

  // Random TX backpressure: after every accepted TX beat, stall 1-5 cycles.
  always @(posedge user_clk) begin
    #1;
    if (bp_en) begin
      if (hs_pending) begin
        stall = $urandom_range(1, 5);
        hs_pending = 0;
      end
      s_axis_tx_tready = (stall == 0);
      if (stall > 0) stall--;
    end else begin
      hs_pending = 0;
    end
  end

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic send_beat(input logic [255:0] data, input logic last);
    bit ok = 0;
    softmc_c2h_tdata  = data;
    softmc_c2h_tlast  = last;
    softmc_c2h_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge user_clk);
      if (softmc_c2h_tready) ok = 1;
      tick();
    end
    check("beat_accepted", 64'(ok), 64'd1);
    if (ok) push_tlp(cfg_completer_id, c2h_base_addr, ref_off, data);
    softmc_c2h_tvalid = 1'b0;
  endtask

  task automatic wait_tlp(input logic last);
    bit fin = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge user_clk);
      if (exp_q.size() == 0 && !s_axis_tx_tvalid) fin = 1;
    end
    tick();
    check("tlp_finished", 64'(fin), 64'd1);
    ref_off = c2h_enable ? (ref_off + 32) % RING_SIZE : 0;
    if (last) exp_done++;
    check("wr_offset", 64'(c2h_wr_offset), 64'(ref_off));
    check("done_count", 64'(done_cnt), 64'(exp_done));
  endtask

  function automatic logic [255:0] seq_data(input logic [31:0] seed);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = seed + 32'(i);
    return d;
  endfunction

  function automatic logic [255:0] rnd_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic flush_after_kill();
    exp_q.delete();
    widx = 0;
    ref_off = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [255:0] d;
    logic         l;
    int           tries;

    vec[0] = '{16'h0100, 32'h8000_0000, 32'h0000_00A0, 1'b1,
               64'h0100_00FF_4000_0008, 64'h0000_00A0_8000_0000,
               64'h0000_0000_0000_00A7, 8'd32, 1};
    vec[1] = '{16'hABCD, 32'h1234_5000, 32'h5555_0000, 1'b0,
               64'hABCD_00FF_4000_0008, 64'h5555_0000_1234_5020,
               64'h0000_0000_5555_0007, 8'd64, 0};
    vec[2] = '{16'hFFFF, 32'hFFFF_F000, 32'hFFFF_FFF8, 1'b1,
               64'hFFFF_00FF_4000_0008, 64'hFFFF_FFF8_FFFF_F040,
               64'h0000_0000_FFFF_FFFF, 8'd96, 1};

    user_reset        = 1'b1;
    user_lnk_up       = 1'b1;
    cfg_completer_id  = 16'h0100;
    cfg_command       = 16'h0004;
    c2h_enable        = 1'b1;
    c2h_base_addr     = 32'h8000_0000;
    softmc_c2h_tdata  = '0;
    softmc_c2h_tvalid = 1'b0;
    softmc_c2h_tlast  = 1'b0;
    s_axis_tx_tready  = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("rst_tlast", 64'(s_axis_tx_tlast), 64'd0);
    check("rst_tkeep", 64'(s_axis_tx_tkeep), 64'd0);
    check("rst_tdata", s_axis_tx_tdata, 64'd0);
    check("rst_c2h_tready", 64'(softmc_c2h_tready), 64'd0);
    check("rst_offset", 64'(c2h_wr_offset), 64'd0);
    check("rst_done", 64'(c2h_done), 64'd0);
    check("rst_src_dsc", 64'(tx_src_dsc), 64'd0);
    user_reset = 1'b0;
    tick();
    check("idle_c2h_tready", 64'(softmc_c2h_tready), 64'd1);

    for (int v = 0; v < 3; v++) begin
      int done_before;
      done_before      = done_cnt;
      cfg_completer_id = vec[v].id;
      c2h_base_addr    = vec[v].base;
      send_beat(seq_data(vec[v].seed), vec[v].last);
      wait_tlp(vec[v].last);
      check("vec_beat0", cap[0], vec[v].w0);
      check("vec_beat1", cap[1], vec[v].w1);
      check("vec_beat5", cap[5], vec[v].w5);
      check("vec_offset", 64'(c2h_wr_offset), 64'(vec[v].off));
      check("vec_done", 64'(done_cnt - done_before), 64'(vec[v].done_inc));
    end

    bp_en = 1;
    for (int n = 0; n < 12; n++) begin
      cfg_completer_id = 16'($urandom);
      c2h_base_addr    = {20'($urandom), 12'h000};
      d = rnd_data();
      l = 1'($urandom_range(0, 1));
      send_beat(d, l);
      wait_tlp(l);
    end
    bp_en = 0;
    s_axis_tx_tready = 1'b1;
    tick();

    c2h_enable = 1'b0;
    repeat (2) tick();
    check("disable_clears_offset", 64'(c2h_wr_offset), 64'd0);
    c2h_enable = 1'b1;
    ref_off = 0;
    c2h_base_addr = 32'hC000_0000;
    for (int n = 0; n < 9; n++) begin
      l = (n == 8);
      send_beat(rnd_data(), l);
      wait_tlp(l);
    end
    check("wrap_dw2", 64'(last_dw2), 64'h0000_0000_C000_0000);
    check("wrap_offset", 64'(c2h_wr_offset), 64'd32);

    cfg_command = 16'h0000;
    softmc_c2h_tvalid = 1'b1;
    tries = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (softmc_c2h_tready || s_axis_tx_tvalid) tries++;
    end
    check("bme_off_no_activity", 64'(tries), 64'd0);
    softmc_c2h_tvalid = 1'b0;
    cfg_command = 16'h0004;
    tick();

    send_beat(seq_data(32'h0000_7700), 1'b1);
    c2h_enable = 1'b0;
    tick();
    check("disabled_c2h_tready", 64'(softmc_c2h_tready), 64'd0);
    wait_tlp(1'b1);
    check("disable_midtlp_offset", 64'(c2h_wr_offset), 64'd0);
    c2h_enable = 1'b1;
    tick();

    send_beat(seq_data(32'h0BAD_0000), 1'b1);
    d = seq_data(32'h0BAD_0000);
    tries = 0;
    while (widx != 3 && tries < 50) begin
      tick();
      tries++;
    end
    check("reached_d34", 64'(widx), 64'd3);
    check("d34_on_bus", s_axis_tx_tdata, {d[159:128], d[127:96]});
    user_reset = 1'b1;
    tick();
    check("rstmid_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("rstmid_offset", 64'(c2h_wr_offset), 64'd0);
    check("rstmid_c2h_tready", 64'(softmc_c2h_tready), 64'd0);
    flush_after_kill();
    user_reset = 1'b0;
    tick();
    check("post_rst_idle", 64'(softmc_c2h_tready), 64'd1);
    send_beat(seq_data(32'h0000_1200), 1'b0);
    wait_tlp(1'b0);

    send_beat(seq_data(32'h0000_3400), 1'b1);
    d = seq_data(32'h0000_3400);
    tries = 0;
    while (widx != 1 && tries < 50) begin
      tick();
      tries++;
    end
    check("reached_h2d0", 64'(widx), 64'd1);
    check("h2d0_on_bus", s_axis_tx_tdata, {d[31:0], c2h_base_addr + 32'd32});
    user_lnk_up = 1'b0;
    tick();
    check("lnk_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("lnk_offset", 64'(c2h_wr_offset), 64'd0);
    check("lnk_c2h_tready", 64'(softmc_c2h_tready), 64'd0);
    flush_after_kill();
    user_lnk_up = 1'b1;
    tick();
    send_beat(seq_data(32'h0000_5600), 1'b1);
    wait_tlp(1'b1);
    repeat (3) tick();
    check("final_done_count", 64'(done_cnt), 64'(exp_done));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
